// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR read-data checker: state encoding, response
// codes and the address-derived expected-data pattern.
package ddr_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0]  RESP_OKAY       = 2'b00;
   localparam logic [31:0] DEFAULT_PATTERN = 32'hA5A5_0000;

   // Expected word for beat idx of a burst starting at base (mod 2^32 add).
   function automatic logic [31:0] exp_data(input logic [31:0] base,
                                            input logic [7:0]  idx,
                                            input logic [31:0] pattern);
      return (base + {24'd0, idx}) ^ pattern;
   endfunction

endpackage

// File: rtl/ddr_rd_pattern_gen.sv
// Registered expected-word generator: loaded on AR acceptance, stepped on each
// accepted beat, so the data compare only sees a flop output.
module ddr_rd_pattern_gen
   import ddr_test_pkg::*;
#(
   parameter int          DATA_W  = 32,
   parameter logic [31:0] PATTERN = DEFAULT_PATTERN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [31:0]       load_addr,
   input  logic              advance,
   output logic [DATA_W-1:0] exp_word
);

   logic [31:0] addr_q, addr_d;
   logic [31:0] exp_q, exp_d;

   always_comb begin
      addr_d = addr_q;
      exp_d  = exp_q;
      if (load) begin
         addr_d = load_addr;
         exp_d  = exp_data(load_addr, 8'd0, PATTERN);
      end else if (advance) begin
         // Precompute the word for the next beat one cycle ahead.
         addr_d = addr_q + 32'd1;
         exp_d  = exp_data(addr_q, 8'd1, PATTERN);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= 32'd0;
         exp_q  <= 32'd0;
      end else begin
         addr_q <= addr_d;
         exp_q  <= exp_d;
      end
   end

   assign exp_word = DATA_W'(exp_q);

endmodule

// File: rtl/ddr_rd_data_chk.sv
// AXI read-data checker: snoops one AR at a time, verifies beat count, RLAST,
// RRESP and address-derived data, and reports a per-burst pass/fail summary.
module ddr_rd_data_chk
   import ddr_test_pkg::*;
#(
   parameter int          DATA_W  = 32,
   parameter logic [31:0] PATTERN = DEFAULT_PATTERN,
   parameter int          GAP     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       araddr,
   input  logic [7:0]        arlen,
   input  logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_data,
   output logic              err_proto,
   output logic [7:0]        first_err_idx
);

   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t      state_q, state_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  idx_q, idx_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic        burst_err_q, burst_err_d;
   logic        data_err_q, data_err_d;
   logic        pass_q, pass_d;
   logic [15:0] err_data_q, err_data_d;
   logic        err_proto_q, err_proto_d;
   logic [7:0]  first_err_idx_q, first_err_idx_d;

   logic              ar_fire;
   logic              ar_accept;
   logic              beat;
   logic              is_last;
   logic              mismatch;
   logic              resp_bad;
   logic              last_bad;
   logic [DATA_W-1:0] exp_word;

   assign ar_fire   = arvalid & arready;
   assign ar_accept = ar_fire & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign rready    = (state_q == ST_RECV);
   assign beat      = rvalid & rready;
   assign is_last   = (idx_q == len_q);
   assign mismatch  = (rdata != exp_word);
   assign resp_bad  = (rresp != RESP_OKAY);
   assign last_bad  = (rlast != is_last);

   ddr_rd_pattern_gen #(
      .DATA_W  (DATA_W),
      .PATTERN (PATTERN)
   ) u_pattern_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (ar_accept),
      .load_addr (araddr),
      .advance   (beat),
      .exp_word  (exp_word)
   );

   always_comb begin
      state_d         = state_q;
      len_d           = len_q;
      idx_d           = idx_q;
      gap_cnt_d       = gap_cnt_q;
      burst_err_d     = burst_err_q;
      data_err_d      = data_err_q;
      pass_d          = pass_q;
      err_data_d      = err_data_q;
      err_proto_d     = err_proto_q;
      first_err_idx_d = first_err_idx_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (state_q == ST_IDLE && rvalid) begin
               err_proto_d = 1'b1;
            end
            if (ar_fire) begin
               state_d         = ST_RECV;
               len_d           = arlen;
               idx_d           = 8'd0;
               burst_err_d     = 1'b0;
               data_err_d      = 1'b0;
               first_err_idx_d = 8'hFF;
            end
         end

         ST_RECV: begin
            if (ar_fire) begin
               err_proto_d = 1'b1;
            end
            if (beat) begin
               if (mismatch) begin
                  data_err_d = 1'b1;
                  if (err_data_q != 16'hFFFF) begin
                     err_data_d = err_data_q + 16'd1;
                  end
                  if (!data_err_q) begin
                     first_err_idx_d = idx_q;
                  end
               end
               if (resp_bad || last_bad) begin
                  err_proto_d = 1'b1;
                  burst_err_d = 1'b1;
               end
               // Beat count alone ends the burst; a stray RLAST is only flagged.
               if (is_last) begin
                  state_d = ST_DONE;
                  pass_d  = !(mismatch || data_err_q || resp_bad || last_bad || burst_err_q);
               end else begin
                  idx_d = idx_q + 8'd1;
                  if (GAP > 0) begin
                     state_d   = ST_GAP;
                     gap_cnt_d = GAP_LOAD;
                  end
               end
            end
         end

         ST_GAP: begin
            if (ar_fire) begin
               err_proto_d = 1'b1;
            end
            if (gap_cnt_q == 4'd0) begin
               state_d = ST_RECV;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         len_q           <= 8'd0;
         idx_q           <= 8'd0;
         gap_cnt_q       <= 4'd0;
         burst_err_q     <= 1'b0;
         data_err_q      <= 1'b0;
         pass_q          <= 1'b0;
         err_data_q      <= 16'd0;
         err_proto_q     <= 1'b0;
         first_err_idx_q <= 8'hFF;
      end else begin
         state_q         <= state_d;
         len_q           <= len_d;
         idx_q           <= idx_d;
         gap_cnt_q       <= gap_cnt_d;
         burst_err_q     <= burst_err_d;
         data_err_q      <= data_err_d;
         pass_q          <= pass_d;
         err_data_q      <= err_data_d;
         err_proto_q     <= err_proto_d;
         first_err_idx_q <= first_err_idx_d;
      end
   end

   assign busy          = (state_q == ST_RECV) | (state_q == ST_GAP);
   assign done          = (state_q == ST_DONE);
   assign pass          = pass_q;
   assign err_data      = err_data_q;
   assign err_proto     = err_proto_q;
   assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_ddr_rd_data_chk.sv
// Directed bench for ddr_rd_data_chk: one instance with GAP=0 and one with
// GAP=2, burst results predicted into a scoreboard and compared at done.
module tb_ddr_rd_data_chk;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid;
   logic        sel;

   logic        rready_o [2];
   logic        busy_o [2];
   logic        done_o [2];
   logic        pass_o [2];
   logic [15:0] err_data_o [2];
   logic        err_proto_o [2];
   logic [7:0]  fidx_o [2];

   logic arvalid_g [2];
   logic rvalid_g [2];

   always #5 clk = ~clk;

   assign arvalid_g[0] = arvalid & ~sel;
   assign arvalid_g[1] = arvalid & sel;
   assign rvalid_g[0]  = rvalid & ~sel;
   assign rvalid_g[1]  = rvalid & sel;

   ddr_rd_data_chk #(.DATA_W(32), .PATTERN(32'hA5A5_0000), .GAP(0)) u_dut0 (
      .clk (clk), .rst (rst), .araddr (araddr), .arlen (arlen),
      .arvalid (arvalid_g[0]), .arready (arready), .rdata (rdata), .rresp (rresp),
      .rlast (rlast), .rvalid (rvalid_g[0]), .rready (rready_o[0]), .busy (busy_o[0]),
      .done (done_o[0]), .pass (pass_o[0]), .err_data (err_data_o[0]),
      .err_proto (err_proto_o[0]), .first_err_idx (fidx_o[0])
   );

   ddr_rd_data_chk #(.DATA_W(32), .PATTERN(32'hA5A5_0000), .GAP(2)) u_dut1 (
      .clk (clk), .rst (rst), .araddr (araddr), .arlen (arlen),
      .arvalid (arvalid_g[1]), .arready (arready), .rdata (rdata), .rresp (rresp),
      .rlast (rlast), .rvalid (rvalid_g[1]), .rready (rready_o[1]), .busy (busy_o[1]),
      .done (done_o[1]), .pass (pass_o[1]), .err_data (err_data_o[1]),
      .err_proto (err_proto_o[1]), .first_err_idx (fidx_o[1])
   );

   logic        rready_s, busy_s, done_s, pass_s, proto_s;
   logic [15:0] err_data_s;
   logic [7:0]  fidx_s;
   assign rready_s   = sel ? rready_o[1]    : rready_o[0];
   assign busy_s     = sel ? busy_o[1]      : busy_o[0];
   assign done_s     = sel ? done_o[1]      : done_o[0];
   assign pass_s     = sel ? pass_o[1]      : pass_o[0];
   assign proto_s    = sel ? err_proto_o[1] : err_proto_o[0];
   assign err_data_s = sel ? err_data_o[1]  : err_data_o[0];
   assign fidx_s     = sel ? fidx_o[1]      : fidx_o[0];

   typedef struct {
      logic        pass;
      logic [15:0] err_data;
      logic [7:0]  fidx;
      logic        proto;
   } exp_t;

   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;
   int   m_err [2] = '{0, 0};
   logic m_proto [2] = '{1'b0, 1'b0};
   int   n_done [2] = '{0, 0};
   int   done_cnt [2] = '{0, 0};

   always @(posedge clk) begin
      if (done_o[0] === 1'b1) done_cnt[0] <= done_cnt[0] + 1;
      if (done_o[1] === 1'b1) done_cnt[1] <= done_cnt[1] + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Run one burst on the selected DUT; -1 disables each injected fault.
   task automatic run_burst(input logic [31:0] base, input int len, input int corrupt,
                            input int early_last, input int bad_resp, input int ovl_before,
                            input int exp_gap);
      exp_t e;
      exp_t got;
      int   waited;
      e.pass = 1'b1;
      e.fidx = 8'hFF;
      if (corrupt >= 0) begin
         e.pass = 1'b0;
         e.fidx = 8'(corrupt);
         m_err[sel] = m_err[sel] + 1;
      end
      if (early_last >= 0 || bad_resp >= 0) begin
         e.pass = 1'b0;
         m_proto[sel] = 1'b1;
      end
      if (ovl_before >= 0) m_proto[sel] = 1'b1;
      e.err_data = 16'(m_err[sel]);
      e.proto    = m_proto[sel];
      sb.push_back(e);

      @(negedge clk);
      araddr = base; arlen = 8'(len); arvalid = 1'b1; arready = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; arready = 1'b0;
      chk("rready_after_ar", rready_s, 1);
      chk("busy_after_ar", busy_s, 1);

      for (int i = 0; i <= len; i++) begin
         if (i == ovl_before) begin
            araddr = 32'hDEAD_0000; arlen = 8'd3; arvalid = 1'b1; arready = 1'b1;
            @(negedge clk);
            arvalid = 1'b0; arready = 1'b0;
         end
         rvalid = 1'b1;
         rdata  = (i == corrupt) ? 32'd0 : ((base + 32'(i)) ^ 32'hA5A5_0000);
         rlast  = (i == len) || (i == early_last);
         rresp  = (i == bad_resp) ? 2'b10 : 2'b00;
         waited = 0;
         while (!rready_s && waited < 40) begin
            @(negedge clk);
            waited++;
         end
         chk("beat_ready", rready_s, 1);
         chk("no_early_done", done_s, 0);
         if (exp_gap >= 0 && i > 0) chk("gap_cycles", waited, exp_gap);
         @(negedge clk);
         rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end

      got = sb.pop_front();
      chk("done_pulse", done_s, 1);
      chk("busy_in_done", busy_s, 0);
      chk("pass", pass_s, got.pass);
      chk("err_data", err_data_s, got.err_data);
      chk("first_err_idx", fidx_s, got.fidx);
      chk("err_proto", proto_s, got.proto);
      n_done[sel] = n_done[sel] + 1;
      @(negedge clk);
      chk("done_once", done_s, 0);
      $display("burst dut=%0d base=%08h beats=%0d pass=%0b err_data=%0d fidx=%02h proto=%0b",
               sel, base, len + 1, pass_s, err_data_s, fidx_s, proto_s);
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0;
      araddr = '0; arlen = '0; arvalid = 1'b0; arready = 1'b0;
      rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("rst_rready", rready_o[d], 0);
         chk("rst_busy", busy_o[d], 0);
         chk("rst_done", done_o[d], 0);
         chk("rst_pass", pass_o[d], 0);
         chk("rst_err_data", err_data_o[d], 0);
         chk("rst_err_proto", err_proto_o[d], 0);
         chk("rst_fidx", fidx_o[d], 8'hFF);
      end
      @(negedge clk);
      rst = 1'b0;

      // Single beat, then back-to-back 8-beat burst with beat 3 corrupted.
      sel = 1'b0;
      run_burst(32'h0000_0001, 0, -1, -1, -1, -1, 0);
      run_burst(32'h0000_2000, 7, 3, -1, -1, -1, 0);
      // Early RLAST on beat 1, then RRESP error on beat 2.
      run_burst(32'h0000_0300, 3, -1, 1, -1, -1, 0);
      run_burst(32'h0000_0400, 3, -1, -1, 2, -1, 0);

      // GAP=2 instance: back-pressure spacing.
      sel = 1'b1;
      run_burst(32'h0000_0100, 3, -1, -1, -1, -1, 2);
      // Unsolicited beat in IDLE must be flagged and left unconsumed.
      @(negedge clk);
      chk("proto_before_unsol", proto_s, 0);
      rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("unsol_rready", rready_s, 0);
      end
      rvalid = 1'b0; rlast = 1'b0;
      chk("unsol_proto", proto_s, 1);
      m_proto[1] = 1'b1;
      // Overlapping AR before beat 2 is ignored; burst still passes.
      run_burst(32'h0000_0800, 3, -1, -1, -1, 2, -1);

      // Reset after 2 of 4 beats, the second one corrupted.
      sel = 1'b0;
      @(negedge clk);
      araddr = 32'h0000_0500; arlen = 8'd3; arvalid = 1'b1; arready = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; arready = 1'b0;
      rvalid = 1'b1; rdata = 32'h0000_0500 ^ 32'hA5A5_0000;
      @(negedge clk);
      rdata = 32'd0;
      @(negedge clk);
      rvalid = 1'b0;
      chk("pre_rst_err_data", err_data_s, 16'(m_err[0] + 1));
      chk("pre_rst_fidx", fidx_s, 8'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_rready", rready_s, 0);
      chk("mid_rst_busy", busy_s, 0);
      chk("mid_rst_err_data", err_data_s, 0);
      chk("mid_rst_fidx", fidx_s, 8'hFF);
      chk("mid_rst_proto", proto_s, 0);
      @(negedge clk);
      rst = 1'b0;
      m_err = '{0, 0};
      m_proto = '{1'b0, 1'b0};
      run_burst(32'h0000_0600, 3, -1, -1, -1, -1, 0);

      chk("done_count0", done_cnt[0], n_done[0]);
      chk("done_count1", done_cnt[1], n_done[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
